// File: rtl/hazard_unit.sv
// Hazard-resolution unit for the 5-stage MIPS pipeline: load-use stalls, branch
// squashes and data-memory wait states, plus a saturating stall-cycle counter.
module hazard_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             memReadIDEX,
  input  logic [4:0]       rtIDEX,
  input  logic [4:0]       rsIFID,
  input  logic [4:0]       rtIFID,
  input  logic             usesRtIFID,
  input  logic             branchTaken,
  input  logic             memBusy,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             idexWrite,
  output logic             exmemWrite,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic [CNT_W-1:0] stallCycles,
  output logic [1:0]       hazState
);

  // state     | meaning
  // RUN       | normal flow, load-use detection active
  // LOADSTALL | bubble sits in ID/EX after a load-use stall, detection suppressed
  // FLUSH     | squashed instructions in the pipe, detection suppressed
  // MEMWAIT   | previous cycle held on memBusy; acts as RUN once memBusy drops
  typedef enum logic [1:0] {
    RUN       = 2'b00,
    LOADSTALL = 2'b01,
    FLUSH     = 2'b10,
    MEMWAIT   = 2'b11
  } haz_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  haz_state_t       r_state;
  haz_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_lu;
  logic             w_lu_en;

  assign w_lu = memReadIDEX && (rtIDEX != 5'd0) &&
                ((rtIDEX == rsIFID) || (usesRtIFID && (rtIDEX == rtIFID)));
  assign w_lu_en = (r_state == RUN) || (r_state == MEMWAIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = RUN;
    pcWrite     = 1'b1;
    ifidWrite   = 1'b1;
    idexWrite   = 1'b1;
    exmemWrite  = 1'b1;
    ifidFlush   = 1'b0;
    idexFlush   = 1'b0;
    if (!reset) begin
      // Hold the whole pipeline frozen and cleared while in reset.
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexWrite  = 1'b0;
      exmemWrite = 1'b0;
      ifidFlush  = 1'b1;
      idexFlush  = 1'b1;
    end else if (memBusy) begin
      pcWrite     = 1'b0;
      ifidWrite   = 1'b0;
      idexWrite   = 1'b0;
      exmemWrite  = 1'b0;
      w_state_nxt = MEMWAIT;
    end else if (branchTaken) begin
      ifidFlush   = 1'b1;
      idexFlush   = 1'b1;
      w_state_nxt = FLUSH;
    end else if (w_lu && w_lu_en) begin
      pcWrite     = 1'b0;
      ifidWrite   = 1'b0;
      idexFlush   = 1'b1;
      w_state_nxt = LOADSTALL;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (!pcWrite && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stallCycles = r_stall_cnt;
  assign hazState    = r_state;

endmodule
